// File: rtl/sync_msg_rx.sv
// sync_msg_rx: receive-side qualifier and queue for state-code messages
// coming out of the 3-stage synchronizer. A code is accepted once it has been
// valid and unchanged for STABLE_CNT consecutive cycles; accepted codes are
// pushed into a small fall-through FIFO drained with a valid/ready handshake.
// Optional feature macro: SYNC_MSG_RX_DEDUP_EN (suppress re-pushing a code
// identical to the last one queued, even across idle gaps).
module sync_msg_rx #(
  parameter int DATA_BIT_WIDTH = 3,
  parameter int STABLE_CNT     = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid_i,
  input  logic [DATA_BIT_WIDTH-1:0]       data_i,
  output logic                            out_valid_o,
  output logic [DATA_BIT_WIDTH-1:0]       out_data_o,
  input  logic                            out_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]     level_o,
  output logic                            overflow_o,
  input  logic                            clr_ovf_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CNT);
  localparam logic [LW-1:0] DEPTH_C  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    COMMIT  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [DATA_BIT_WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]             level_q, level_d;
  logic                      ovf_q, ovf_d;
  logic [DATA_BIT_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic ovf_set;
  logic space;
  logic dup;

  // Pops only happen against a non-empty queue; a pop frees a slot for a
  // push landing in the same cycle.
  assign pop   = (level_q != '0) && out_ready_i;
  assign space = (level_q < DEPTH_C) || pop;

`ifdef SYNC_MSG_RX_DEDUP_EN
  logic [DATA_BIT_WIDTH-1:0] last_q, last_d;
  logic                      last_vld_q, last_vld_d;

  assign dup = last_vld_q && (cand_q == last_q);

  // Remember the most recently queued code.
  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (push) begin
      last_d     = cand_q;
      last_vld_d = 1'b1;
    end
  end

  // Validity of the remembered code is control state and is reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_vld_q <= 1'b0;
    else       last_vld_q <= last_vld_d;
  end

  // The remembered code itself is only meaningful while last_vld_q is set.
  always_ff @(posedge clk) begin
    last_q <= last_d;
  end
`else
  assign dup = 1'b0;
`endif

  // Qualification FSM: next state, candidate tracking and commit decision.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          cand_d  = data_i;
          cnt_d   = CW'(1);
          state_d = (STABLE_CNT == 1) ? COMMIT : QUALIFY;
        end
      end
      QUALIFY: begin
        if (!valid_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (data_i == cand_q) begin
          cnt_d = cnt_q + CW'(1);
          if ((cnt_q + CW'(1)) == STABLE_C) state_d = COMMIT;
        end else begin
          cand_d = data_i;
          cnt_d  = CW'(1);
        end
      end
      COMMIT: begin
        state_d = HOLD;
        if (!dup) begin
          if (space) push    = 1'b1;
          else       ovf_set = 1'b1;
        end
      end
      HOLD: begin
        if (!valid_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (data_i != cand_q) begin
          cand_d  = data_i;
          cnt_d   = CW'(1);
          state_d = (STABLE_CNT == 1) ? COMMIT : QUALIFY;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO pointer/level bookkeeping and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A new drop outranks a clear requested in the same cycle.
    if (ovf_set)        ovf_d = 1'b1;
    else if (clr_ovf_i) ovf_d = 1'b0;
    else                ovf_d = ovf_q;
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Data registers: candidate and FIFO storage carry no reset; they are only
  // observed while the FSM or level says they hold something.
  always_ff @(posedge clk) begin
    cand_q <= cand_d;
    if (push) mem_q[wr_ptr_q] <= cand_q;
  end

  assign out_valid_o = (level_q != '0);
  assign out_data_o  = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign level_o     = level_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_sync_msg_rx.sv
// Directed bench for sync_msg_rx with default parameters
// (3-bit codes, STABLE_CNT=2, FIFO_DEPTH=4).
module tb_sync_msg_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid_i = 1'b0;
  logic [2:0] data_i = '0;
  logic       out_valid_o;
  logic [2:0] out_data_o;
  logic       out_ready_i = 1'b0;
  logic [2:0] level_o;
  logic       overflow_o;
  logic       clr_ovf_i = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sync_msg_rx #(.DATA_BIT_WIDTH(3), .STABLE_CNT(2), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .out_ready_i(out_ready_i),
    .level_o    (level_o),
    .overflow_o (overflow_o),
    .clr_ovf_i  (clr_ovf_i)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid_i = 1'b0; data_i = '0; out_ready_i = 1'b0; clr_ovf_i = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  // Present a code for three edges (qualify, commit, push), then one idle edge.
  task automatic send_code(input logic [2:0] c);
    valid_i = 1'b1; data_i = c;
    repeat (3) step();
    valid_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    n_checks++; if (out_valid_o !== 1'b0) $display("FAIL rst_valid got=%b exp=0", out_valid_o); else n_pass++;
    n_checks++; if (out_data_o !== 3'd0) $display("FAIL rst_data got=%0d exp=0", out_data_o); else n_pass++;
    n_checks++; if (level_o !== 3'd0) $display("FAIL rst_level got=%0d exp=0", level_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL rst_ovf got=%b exp=0", overflow_o); else n_pass++;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    do_reset();
    valid_i = 1'b1; data_i = 3'd5;
    step(); step();
    n_checks++; if (out_valid_o !== 1'b0) $display("FAIL basic_early got=%b exp=0", out_valid_o); else n_pass++;
    step();
    n_checks++; if (out_valid_o !== 1'b1) $display("FAIL basic_valid got=%b exp=1", out_valid_o); else n_pass++;
    n_checks++; if (out_data_o !== 3'd5) $display("FAIL basic_data got=%0d exp=5", out_data_o); else n_pass++;
    n_checks++; if (level_o !== 3'd1) $display("FAIL basic_level got=%0d exp=1", level_o); else n_pass++;
    step();
    n_checks++; if (level_o !== 3'd1) $display("FAIL basic_hold_level got=%0d exp=1", level_o); else n_pass++;
    valid_i = 1'b0;
    step();
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    n_checks++; if (level_o !== 3'd0) $display("FAIL basic_drain_level got=%0d exp=0", level_o); else n_pass++;
    n_checks++; if (out_data_o !== 3'd0) $display("FAIL basic_empty_data got=%0d exp=0", out_data_o); else n_pass++;
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    n_checks++; if (level_o !== 3'd0) $display("FAIL empty_pop_level got=%0d exp=0", level_o); else n_pass++;
  endtask

  task automatic test_glitch();
    logic [2:0] seq [4];
    do_reset();
    seq[0] = 3'd5; seq[1] = 3'd2; seq[2] = 3'd5; seq[3] = 3'd5;
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = seq[i];
      step();
    end
    valid_i = 1'b0;
    step(); step();
    n_checks++; if (level_o !== 3'd1) $display("FAIL glitch_level got=%0d exp=1", level_o); else n_pass++;
    n_checks++; if (out_data_o !== 3'd5) $display("FAIL glitch_data got=%0d exp=5", out_data_o); else n_pass++;
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    n_checks++; if (level_o !== 3'd0) $display("FAIL glitch_only_one got=%0d exp=0", level_o); else n_pass++;
  endtask

  task automatic test_drop();
    do_reset();
    valid_i = 1'b1; data_i = 3'd6;
    step();
    valid_i = 1'b0;
    repeat (3) step();
    n_checks++; if (level_o !== 3'd0) $display("FAIL drop_level got=%0d exp=0", level_o); else n_pass++;
    n_checks++; if (out_valid_o !== 1'b0) $display("FAIL drop_valid got=%b exp=0", out_valid_o); else n_pass++;
    send_code(3'd6);
    n_checks++; if (out_data_o !== 3'd6) $display("FAIL drop_then_ok got=%0d exp=6", out_data_o); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [2:0] exp_q [4];
    do_reset();
    send_code(3'd1); send_code(3'd2); send_code(3'd3); send_code(3'd4);
    n_checks++; if (level_o !== 3'd4) $display("FAIL ovf_fill_level got=%0d exp=4", level_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL ovf_fill_flag got=%b exp=0", overflow_o); else n_pass++;
    send_code(3'd7);
    n_checks++; if (overflow_o !== 1'b1) $display("FAIL ovf_set got=%b exp=1", overflow_o); else n_pass++;
    n_checks++; if (level_o !== 3'd4) $display("FAIL ovf_level got=%0d exp=4", level_o); else n_pass++;
    n_checks++; if (out_data_o !== 3'd1) $display("FAIL ovf_head got=%0d exp=1", out_data_o); else n_pass++;
    // Qualify 0 with a pop on the commit edge.
    valid_i = 1'b1; data_i = 3'd0;
    step(); step();
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    n_checks++; if (level_o !== 3'd4) $display("FAIL pushpop_level got=%0d exp=4", level_o); else n_pass++;
    n_checks++; if (out_data_o !== 3'd2) $display("FAIL pushpop_head got=%0d exp=2", out_data_o); else n_pass++;
    valid_i = 1'b0;
    step();
    clr_ovf_i = 1'b1;
    step();
    clr_ovf_i = 1'b0;
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", overflow_o); else n_pass++;
    // Drop while a clear is requested on the same edge: the set wins.
    valid_i = 1'b1; data_i = 3'd6;
    step(); step();
    clr_ovf_i = 1'b1;
    step();
    clr_ovf_i = 1'b0;
    n_checks++; if (overflow_o !== 1'b1) $display("FAIL ovf_set_wins got=%b exp=1", overflow_o); else n_pass++;
    valid_i = 1'b0;
    step();
    exp_q[0] = 3'd2; exp_q[1] = 3'd3; exp_q[2] = 3'd4; exp_q[3] = 3'd0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_data_o !== exp_q[i]) $display("FAIL ovf_drain_%0d got=%0d exp=%0d", i, out_data_o, exp_q[i]); else n_pass++;
      step();
    end
    out_ready_i = 1'b0;
    n_checks++; if (level_o !== 3'd0) $display("FAIL ovf_drain_level got=%0d exp=0", level_o); else n_pass++;
  endtask

  task automatic test_dedup();
    logic [2:0] exp_lvl;
`ifdef SYNC_MSG_RX_DEDUP_EN
    exp_lvl = 3'd1;
`else
    exp_lvl = 3'd2;
`endif
    do_reset();
    send_code(3'd5);
    step();
    send_code(3'd5);
    n_checks++; if (level_o !== exp_lvl) $display("FAIL dedup_level got=%0d exp=%0d", level_o, exp_lvl); else n_pass++;
    n_checks++; if (out_data_o !== 3'd5) $display("FAIL dedup_head got=%0d exp=5", out_data_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_code(3'd1); send_code(3'd2);
    n_checks++; if (level_o !== 3'd2) $display("FAIL midrst_pre_level got=%0d exp=2", level_o); else n_pass++;
    valid_i = 1'b1; data_i = 3'd3;
    step();
    #2 reset = 1'b1;
    #1;
    n_checks++; if (level_o !== 3'd0) $display("FAIL midrst_level got=%0d exp=0", level_o); else n_pass++;
    n_checks++; if (out_valid_o !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", out_valid_o); else n_pass++;
    n_checks++; if (out_data_o !== 3'd0) $display("FAIL midrst_data got=%0d exp=0", out_data_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL midrst_ovf got=%b exp=0", overflow_o); else n_pass++;
    valid_i = 1'b0;
    #1 reset = 1'b0;
    step();
    n_checks++; if (level_o !== 3'd0) $display("FAIL midrst_cand_lost got=%0d exp=0", level_o); else n_pass++;
    send_code(3'd3);
    n_checks++; if (level_o !== 3'd1) $display("FAIL midrst_after_level got=%0d exp=1", level_o); else n_pass++;
    n_checks++; if (out_data_o !== 3'd3) $display("FAIL midrst_after_data got=%0d exp=3", out_data_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_drop();
    test_overflow();
    test_dedup();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
